// File: rtl/mips_pkg.sv
`default_nettype none
// mips_pkg: load/store opcode codes, access sizes and the memory-stage FSM state type.
package mips_pkg;

  localparam logic [7:0] OP_LB  = 8'h20;
  localparam logic [7:0] OP_LH  = 8'h21;
  localparam logic [7:0] OP_LW  = 8'h23;
  localparam logic [7:0] OP_LBU = 8'h24;
  localparam logic [7:0] OP_LHU = 8'h25;
  localparam logic [7:0] OP_SB  = 8'h28;
  localparam logic [7:0] OP_SH  = 8'h29;
  localparam logic [7:0] OP_SW  = 8'h2B;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ADDR   = 3'd1,
    S_DATA   = 3'd2,
    S_HOLD   = 3'd3,
    S_CANCEL = 3'd4
  } mem_state_e;

  function automatic logic [1:0] op_size(input logic [7:0] op);
    case (op)
      OP_LB, OP_LBU, OP_SB: return SIZE_BYTE;
      OP_LH, OP_LHU, OP_SH: return SIZE_HALF;
      default:              return SIZE_WORD;
    endcase
  endfunction

  function automatic logic op_signed(input logic [7:0] op);
    return (op == OP_LB) || (op == OP_LH);
  endfunction

endpackage
`default_nettype wire

// File: rtl/load_ext.sv
`default_nettype none
// load_ext: selects the addressed byte/half of a load word and sign- or zero-extends it.
module load_ext
  import mips_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [1:0]  size_i,
  input  logic        sign_i,
  output logic [31:0] data_o
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    case (addr_lo_i)
      2'd0:    w_byte = rdata_i[7:0];
      2'd1:    w_byte = rdata_i[15:8];
      2'd2:    w_byte = rdata_i[23:16];
      default: w_byte = rdata_i[31:24];
    endcase
    w_half = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    case (size_i)
      SIZE_BYTE: data_o = {{24{sign_i & w_byte[7]}}, w_byte};
      SIZE_HALF: data_o = {{16{sign_i & w_half[15]}}, w_half};
      default:   data_o = rdata_i;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mem_access_m.sv
`default_nettype none
// mem_access_m: M-stage data-bus controller (store formatting, load extension, stall, flush drain).
// MEM_ADDR_EXC_EN: defined = misaligned accesses raise adelM_mem/adesM; undefined = addresses masked to alignment.
module mem_access_m
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        memenM,
  input  logic        MemWriteM,
  input  logic [7:0]  ALUControlM,
  input  logic [31:0] aluoutM,
  input  logic [31:0] writedataM,
  input  logic        flush,
  input  logic        stall_in,
  output logic        data_req,
  output logic        data_wr,
  output logic [1:0]  data_size,
  output logic [31:0] data_addr,
  output logic [3:0]  data_wstrb,
  output logic [31:0] data_wdata,
  input  logic        data_addr_ok,
  input  logic        data_data_ok,
  input  logic [31:0] data_rdata,
  output logic [31:0] readdataM,
  output logic        stall_mem,
  output logic        adelM_mem,
  output logic        adesM,
  output logic [31:0] bad_addr_mem
);

  mem_state_e  state_q;
  logic        flush_seen_q;
  logic [31:0] rdata_q;
  logic        wr_q;
  logic        sign_q;
  logic [1:0]  size_q;
  logic [31:0] addr_q;
  logic [3:0]  wstrb_q;
  logic [31:0] wdata_q;

  logic [1:0]  w_size;
  logic        w_sign;
  logic        w_addr_err;
  logic [31:0] w_addr;
  logic [3:0]  w_wstrb;
  logic [31:0] w_wdata;
  logic [31:0] w_ext;
  logic        w_go;

  assign w_size = op_size(ALUControlM);
  assign w_sign = op_signed(ALUControlM);

`ifdef MEM_ADDR_EXC_EN
  logic w_misalign;
  assign w_misalign   = ((w_size == SIZE_HALF) & aluoutM[0]) |
                        ((w_size == SIZE_WORD) & (|aluoutM[1:0]));
  assign w_addr_err   = memenM & w_misalign;
  assign adelM_mem    = w_addr_err & ~MemWriteM;
  assign adesM        = w_addr_err & MemWriteM;
  assign bad_addr_mem = aluoutM;
  assign w_addr       = aluoutM;
`else
  assign w_addr_err   = 1'b0;
  assign adelM_mem    = 1'b0;
  assign adesM        = 1'b0;
  assign bad_addr_mem = 32'h0;
  assign w_addr       = (w_size == SIZE_BYTE) ? aluoutM :
                        (w_size == SIZE_HALF) ? {aluoutM[31:1], 1'b0} :
                                                {aluoutM[31:2], 2'b00};
`endif

  always_comb begin
    case (w_size)
      SIZE_BYTE: begin
        w_wstrb = 4'b0001 << w_addr[1:0];
        w_wdata = {4{writedataM[7:0]}};
      end
      SIZE_HALF: begin
        w_wstrb = 4'b0011 << {w_addr[1], 1'b0};
        w_wdata = {2{writedataM[15:0]}};
      end
      default: begin
        w_wstrb = 4'hF;
        w_wdata = writedataM;
      end
    endcase
    if (!MemWriteM) w_wstrb = 4'h0;
  end

  assign w_go = memenM & ~flush & ~w_addr_err & (state_q == S_IDLE);

  // While waiting in ADDR the request replays the fields captured at issue.
  assign data_req   = w_go | (state_q == S_ADDR);
  assign data_wr    = (state_q == S_ADDR) ? wr_q    : MemWriteM;
  assign data_size  = (state_q == S_ADDR) ? size_q  : w_size;
  assign data_addr  = (state_q == S_ADDR) ? addr_q  : w_addr;
  assign data_wstrb = (state_q == S_ADDR) ? wstrb_q : w_wstrb;
  assign data_wdata = (state_q == S_ADDR) ? wdata_q : w_wdata;

  load_ext u_load_ext (
    .rdata_i   (data_rdata),
    .addr_lo_i (addr_q[1:0]),
    .size_i    (size_q),
    .sign_i    (sign_q),
    .data_o    (w_ext)
  );

  assign stall_mem = w_go | (state_q == S_ADDR) | (state_q == S_CANCEL) |
                     ((state_q == S_DATA) & ~data_data_ok);

  assign readdataM = ((state_q == S_DATA) & data_data_ok & ~flush) ? w_ext : rdata_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      flush_seen_q <= 1'b0;
      rdata_q      <= 32'h0;
      wr_q         <= 1'b0;
      sign_q       <= 1'b0;
      size_q       <= SIZE_BYTE;
      addr_q       <= 32'h0;
      wstrb_q      <= 4'h0;
      wdata_q      <= 32'h0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (w_go) begin
            wr_q         <= MemWriteM;
            sign_q       <= w_sign;
            size_q       <= w_size;
            addr_q       <= w_addr;
            wstrb_q      <= w_wstrb;
            wdata_q      <= w_wdata;
            flush_seen_q <= 1'b0;
            state_q      <= data_addr_ok ? S_DATA : S_ADDR;
          end
        end
        S_ADDR: begin
          if (data_addr_ok) begin
            state_q      <= (flush_seen_q | flush) ? S_CANCEL : S_DATA;
            flush_seen_q <= 1'b0;
          end else begin
            flush_seen_q <= flush_seen_q | flush;
          end
        end
        S_DATA: begin
          if (data_data_ok) begin
            if (flush) begin
              state_q <= S_IDLE;
            end else begin
              rdata_q <= w_ext;
              state_q <= stall_in ? S_HOLD : S_IDLE;
            end
          end else if (flush) begin
            state_q <= S_CANCEL;
          end
        end
        S_HOLD: begin
          if (flush || !stall_in) state_q <= S_IDLE;
        end
        S_CANCEL: begin
          if (data_data_ok) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
